// File: rtl/sd_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_rx_pkg
// Brief    : Shared types and defaults for the SD serial receive path.
// Revision : 1.0 - initial release
// ============================================================================
package sd_rx_pkg;

    typedef enum logic {
        RX_HUNT = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

    localparam int SD_WORD_BITS = 8;

endpackage : sd_rx_pkg
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module   : flex_counter
// Brief    : Enabled bit counter that wraps at ROLLOVER and flags the wrap.
// Revision : 1.0 - initial release
// ============================================================================
module flex_counter #(
    parameter int ROLLOVER = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear_i,
    input  logic count_enable_i,
    output logic rollover_o
);

    localparam int              CW   = $clog2(ROLLOVER + 1);
    localparam logic [CW-1:0]   LAST = CW'(ROLLOVER - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The completing strobe returns the count to zero, so NUM_BITS itself is never stored.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign rollover_o = count_enable_i && (count_q == LAST);

endmodule : flex_counter
`default_nettype wire

// File: rtl/sd_stp_receiver.sv
`default_nettype none
// ============================================================================
// Module   : sd_stp_receiver
// Brief    : Serial-to-parallel SD data receiver with start-bit hunt and
//            valid/ack word handshake with sticky overrun.
// Revision : 1.0 - initial release
// ============================================================================
module sd_stp_receiver
    import sd_rx_pkg::*;
#(
    parameter int NUM_BITS  = SD_WORD_BITS,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    input  logic                hunt_enable,
    input  logic                clear,
    input  logic                data_ack,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic                data_valid,
    output logic                busy,
    output logic                overrun
);

    rx_state_t           state_q;
    rx_state_t           state_d;
    logic [NUM_BITS-1:0] shift_q;
    logic [NUM_BITS-1:0] shift_d;
    logic [NUM_BITS-1:0] pout_q;
    logic [NUM_BITS-1:0] pout_d;
    logic                valid_q;
    logic                valid_d;
    logic                overrun_q;
    logic                overrun_d;
    logic [NUM_BITS-1:0] w_shift_next;
    logic                w_capture;
    logic                w_complete;

    // In HUNT with hunting on, only a 0 (the start bit) opens a word; it is kept as data.
    assign w_capture = shift_enable && !clear &&
                       ((state_q == RX_RECV) || !hunt_enable || !serial_in);

    generate
        if (SHIFT_MSB) begin : g_shift_msb
            assign w_shift_next = {shift_q[NUM_BITS-2:0], serial_in};
        end else begin : g_shift_lsb
            assign w_shift_next = {serial_in, shift_q[NUM_BITS-1:1]};
        end
    endgenerate

    flex_counter #(
        .ROLLOVER (NUM_BITS)
    ) u_bit_counter (
        .clk            (clk),
        .n_rst          (n_rst),
        .clear_i        (clear),
        .count_enable_i (w_capture),
        .rollover_o     (w_complete)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= RX_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = RX_HUNT;
        end else begin
            case (state_q)
                RX_HUNT: if (w_capture) state_d = RX_RECV;
                RX_RECV: if (w_complete && hunt_enable) state_d = RX_HUNT;
                default: state_d = RX_HUNT;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == RX_RECV);
    end

    always_comb begin
        shift_d   = shift_q;
        pout_d    = pout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (clear) begin
            shift_d   = '1;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (w_capture) begin
                shift_d = w_shift_next;
            end
            if (w_complete) begin
                pout_d  = w_shift_next;
                valid_d = 1'b1;
                if (valid_q && !data_ack) begin
                    overrun_d = 1'b1;
                end
            end else if (data_ack) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q   <= '1;
            pout_q    <= '1;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign parallel_out = pout_q;
    assign data_valid   = valid_q;
    assign overrun      = overrun_q;

endmodule : sd_stp_receiver
`default_nettype wire

// File: doc/sd_stp_receiver.md
Name: sd_stp_receiver

Overview:
- Serial-to-parallel receiver for the SD card serial data path; the receive-side counterpart of the team's flexible parallel-to-serial shifter.
- Samples one bit per shift_enable strobe and assembles NUM_BITS-bit words.
- Optionally hunts for a start bit, since the idle line is high.
- Presents each word with a valid/ack handshake to the AES/controller side and flags overruns.

Parameters:
- NUM_BITS, 8: word width; legal range 2..32.
- SHIFT_MSB, 1: 1 = first received bit ends at parallel_out[NUM_BITS-1] (shift toward MSB, insert at bit 0); 0 = first received bit ends at parallel_out[0] (shift toward LSB, insert at MSB).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- shift_enable  input  1  sample serial_in this cycle.
- serial_in  input  1  serial data; idles high.
- hunt_enable  input  1  1 = each word must begin with a 0 start bit; 0 = contiguous streaming words.
- clear  input  1  synchronous flush: discard partial word, clear flags.
- data_ack  input  1  consumer accepts parallel_out.
- parallel_out  output  NUM_BITS  last completed word.
- data_valid  output  1  parallel_out holds an unacknowledged word.
- busy  output  1  word reception in progress (state RECV).
- overrun  output  1  sticky; a word completed while the previous word was still unacknowledged.

Behaviour:
- Reset (n_rst low, asynchronous): state=RX_HUNT, bit count=0, shift register='1, parallel_out='1, data_valid=0, busy=0, overrun=0.
- Priority: reset > clear > shift/complete logic. Clear forces the reset values except parallel_out, which is held. A shift_enable in the same cycle as clear is ignored.
- State RX_HUNT:
  - shift_enable=1, hunt_enable=1, serial_in=1: bit discarded, stay in HUNT.
  - shift_enable=1, hunt_enable=1, serial_in=0: the 0 is captured as the first data bit (SD tokens/responses carry the start bit inside the word), count=1, go to RX_RECV.
  - shift_enable=1, hunt_enable=0: bit captured unconditionally, count=1, go to RX_RECV.
- State RX_RECV:
  - Each shift_enable shifts serial_in into the register per SHIFT_MSB and increments count.
  - On the strobe that brings count to NUM_BITS (the completion edge):
    - the assembled word, including that bit, loads parallel_out;
    - data_valid=1 from the next cycle;
    - count=0;
    - next state is RX_HUNT if hunt_enable=1 at that edge, else RX_RECV, so streaming continues with no gap bit.
- Latency: parallel_out and data_valid are registered; both update on the clock edge that samples the last bit.
- busy is 1 exactly while state=RX_RECV.
- Handshake:
  - data_valid stays 1 until a cycle with data_ack=1, then clears on that edge.
  - data_ack while data_valid=0 is ignored.
- Completion coinciding with the handshake:
  - Completion and data_ack in the same cycle: the new word loads, data_valid remains 1, no overrun.
  - Completion while data_valid=1 and data_ack=0: the new word overwrites parallel_out, data_valid stays 1, overrun sets and stays set until clear or reset.
- hunt_enable changing mid-word has no effect until the next completion edge.
- shift_enable held high for consecutive cycles: one bit per cycle; back-to-back words are supported.
- Counter width: $clog2(NUM_BITS+1). The count never exceeds NUM_BITS.

Decomposition:
- Package sd_rx_pkg:
  - typedef enum logic {RX_HUNT, RX_RECV} rx_state_t;
  - localparam default word width SD_WORD_BITS=8.
- One sub-module: flex_counter, the bit counter with enable, synchronous clear and rollover value NUM_BITS, producing the completion flag.
- The shift register and FSM stay in sd_stp_receiver.

Test Plan:
1. Reset, then hunt_enable=1, SHIFT_MSB=1; drive 1,1,1 then 0,1,0,1,0,0,1,1 with one strobe each -> the three leading 1s are discarded; parallel_out=8'h53 and data_valid=1 the cycle after the 8th bit; busy high for bits 1-7 of the word only.
2. hunt_enable=0, SHIFT_MSB=0; stream 16 bits forming 8'hA5 then 8'h3C (LSB-first arrival) with continuous strobes; ack each word -> two valid words 8'hA5 then 8'h3C, no gap bit, overrun=0.
3. Streaming with no ack for two words -> second completion gives parallel_out = second word, data_valid=1, overrun=1; overrun stays 1 after later acks; clear drops it to 0.
4. data_ack asserted on the exact completion cycle of the next word -> data_valid stays 1 with the new word; overrun=0.
5. Assert clear after 4 of 8 bits, then send a fresh word 8'hC3 -> first output is 8'hC3, not a mix with the partial bits; parallel_out held its prior value across clear.
6. Assert n_rst low mid-word, asynchronously between clock edges -> outputs go immediately to the reset values (parallel_out='1, flags 0); the next word is received correctly from RX_HUNT.
